aes_key_expand: RTL and testbench

Iterative AES-128 key-schedule engine that sits directly upstream of `aes_sbox` on its key path. It drives the sbox key port with RotWord of the last round-key word and consumes the substituted word in the same cycle. From that result it produces round keys 0..10, one per accepted handshake, to the round datapath.

---
 rtl/aes_key_expand_if.sv | 29 ++
 rtl/aes_key_expand.sv | 142 ++++++++++++++
 tb/tb_aes_key_expand.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_key_expand_if.sv
// AES key-path types and the round-key valid/ready bundle.
// Package precedes the interface so both share one file.
package aes_pkg;
    typedef logic [15:0][7:0] aes_128;
    typedef logic [3:0][7:0]  aes_32;
endpackage

interface aes_key_expand_if;
    import aes_pkg::*;

    logic       rk_valid;
    logic       rk_ready;
    logic [3:0] rk_round;
    aes_128     rk_out;

    modport master (
        output rk_valid,
        output rk_round,
        output rk_out,
        input  rk_ready
    );

    modport slave (
        input  rk_valid,
        input  rk_round,
        input  rk_out,
        output rk_ready
    );
endinterface

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: one round key per handshake,
// using the external aes_sbox combinationally on the key path.
module aes_key_expand
    import aes_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   start,
    input  aes_128 key_in,
    output logic   busy,
    output logic   done,
    output aes_32  sbox_key_word,
    output logic   sbox_key_gen,
    input  aes_32  sbox_key_sub,
    aes_key_expand_if.master rk
);

    typedef enum logic {
        IDLE,
        EXPAND
    } state_t;

    localparam logic [3:0] LAST = 4'(NR);

    state_t     state_q, state_d;
    aes_128     key_q, key_d, key_nxt;
    logic [3:0] round_q, round_d;
    logic       valid_q, valid_d;
    logic       done_q, done_d;

    aes_32      w0, w1, w2, w3;
    aes_32      rot, t;
    aes_32      n0, n1, n2, n3;
    logic [7:0] rcon;
    logic       xfer;
    logic       last;

    assign w0 = key_q[3:0];
    assign w1 = key_q[7:4];
    assign w2 = key_q[11:8];
    assign w3 = key_q[15:12];

    // RotWord in FIPS byte order: byte 0 takes w3 byte 1
    always_comb begin
        rot    = '0;
        rot[0] = w3[1];
        rot[1] = w3[2];
        rot[2] = w3[3];
        rot[3] = w3[0];
    end

    // rcon for the key being produced (round_q + 1)
    always_comb begin
        rcon = 8'h00;
        unique case (round_q)
            4'd0:    rcon = 8'h01;
            4'd1:    rcon = 8'h02;
            4'd2:    rcon = 8'h04;
            4'd3:    rcon = 8'h08;
            4'd4:    rcon = 8'h10;
            4'd5:    rcon = 8'h20;
            4'd6:    rcon = 8'h40;
            4'd7:    rcon = 8'h80;
            4'd8:    rcon = 8'h1b;
            4'd9:    rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    always_comb begin
        t    = sbox_key_sub;
        t[0] = sbox_key_sub[0] ^ rcon;
    end

    assign n0      = w0 ^ t;
    assign n1      = w1 ^ n0;
    assign n2      = w2 ^ n1;
    assign n3      = w3 ^ n2;
    assign key_nxt = {n3, n2, n1, n0};

    assign xfer = valid_q & rk.rk_ready;
    assign last = (round_q == LAST);

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    key_d   = key_in;
                    round_d = 4'd0;
                    valid_d = 1'b1;
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                if (xfer) begin
                    if (last) begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        key_d   = key_nxt;
                        round_d = round_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= '0;
            round_q <= 4'd0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign busy          = (state_q == EXPAND);
    assign done          = done_q;
    assign sbox_key_gen  = busy;
    assign sbox_key_word = busy ? rot : '0;

    assign rk.rk_valid = valid_q;
    assign rk.rk_round = round_q;
    assign rk.rk_out   = key_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Scoreboard bench for aes_key_expand with an arithmetic
// S-box and FIPS-style key-schedule reference model.
module tb_aes_key_expand;
    import aes_pkg::*;

    typedef struct {
        int     rnd;
        aes_128 key;
    } exp_t;

    logic   clk;
    logic   rst_n;
    logic   start;
    aes_128 key_in;
    logic   busy;
    logic   done;
    aes_32  sbox_key_word;
    logic   sbox_key_gen;
    aes_32  sbox_key_sub;

    aes_key_expand_if bus ();

    aes_key_expand #(.NR(10)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .key_in       (key_in),
        .busy         (busy),
        .done         (done),
        .sbox_key_word(sbox_key_word),
        .sbox_key_gen (sbox_key_gen),
        .sbox_key_sub (sbox_key_sub),
        .rk           (bus)
    );

    int total = 0;
    int bad   = 0;
    int xfers = 0;

    exp_t   sb[$];
    aes_128 seen[11];

    logic   mon_off = 1'b0;
    logic   bp_on   = 1'b0;
    logic   rnd_rdy = 1'b0;
    logic   s3, s10;
    int     stall_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] xt(logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] r = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = xt(x);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(logic [7:0] a, int n);
        logic [15:0] d = {a, a};
        return d[15-n -: 8];
    endfunction

    // Multiplicative inverse (a^254) followed by the affine map
    function automatic logic [7:0] sbox(logic [7:0] a);
        logic [7:0] inv = 8'h01;
        logic [7:0] p   = a;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) inv = gmul(inv, p);
            p = gmul(p, p);
        end
        return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^
               rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    endfunction

    always_comb begin
        sbox_key_sub = '0;
        for (int j = 0; j < 4; j++)
            sbox_key_sub[j] = sbox(sbox_key_word[j]);
    end

    function automatic aes_128 from_hex(logic [127:0] h);
        aes_128 r;
        for (int k = 0; k < 16; k++) r[k] = h[127-8*k -: 8];
        return r;
    endfunction

    task automatic push_expected(aes_128 key);
        logic [7:0] w[44][4];
        logic [7:0] tmp[4];
        logic [7:0] rc = 8'h01;
        aes_128     rk;
        exp_t       e;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) w[i][j] = key[4*i+j];
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[i-1][j];
            if (i % 4 == 0) begin
                for (int j = 0; j < 4; j++)
                    tmp[j] = sbox(w[i-1][(j+1)%4]);
                tmp[0] = tmp[0] ^ rc;
                rc = xt(rc);
            end
            for (int j = 0; j < 4; j++) w[i][j] = w[i-4][j] ^ tmp[j];
        end
        for (int r = 0; r <= 10; r++) begin
            for (int k = 0; k < 16; k++) rk[k] = w[4*r + k/4][k%4];
            e.rnd = r;
            e.key = rk;
            sb.push_back(e);
        end
    endtask

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Ready driver: optional random pattern plus forced 5-cycle stalls
    initial begin
        bus.rk_ready = 1'b0;
        stall_cnt = 0;
        s3 = 1'b0;
        s10 = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (stall_cnt > 0) begin
                stall_cnt--;
                bus.rk_ready = 1'b0;
            end else if (bp_on && bus.rk_valid &&
                         bus.rk_round == 4'd3 && !s3) begin
                s3 = 1'b1;
                stall_cnt = 4;
                bus.rk_ready = 1'b0;
            end else if (bp_on && bus.rk_valid &&
                         bus.rk_round == 4'd10 && !s10) begin
                s10 = 1'b1;
                stall_cnt = 4;
                bus.rk_ready = 1'b0;
            end else begin
                bus.rk_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard on each transfer
    initial begin
        logic       prev_stall = 1'b0;
        logic       exp_done   = 1'b0;
        aes_128     prev_key;
        logic [3:0] prev_round;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (!rst_n || mon_off) begin
                prev_stall = 1'b0;
                exp_done = 1'b0;
            end else begin
                chk("done", done, exp_done);
                if (exp_done) chk("busy_in_done", busy, 0);
                if (prev_stall) begin
                    chk("stall_key", bus.rk_out, prev_key);
                    chk("stall_round", bus.rk_round, prev_round);
                    chk("stall_valid", bus.rk_valid, 1);
                end
                exp_done = 1'b0;
                if (bus.rk_valid && bus.rk_ready) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL extra_xfer: round %0d, none expected",
                                 bus.rk_round);
                    end else begin
                        e = sb.pop_front();
                        chk("round", bus.rk_round, e.rnd);
                        chk("key", bus.rk_out, e.key);
                        seen[e.rnd] = bus.rk_out;
                        xfers++;
                        if (e.rnd == 10) exp_done = 1'b1;
                    end
                end
                prev_stall = bus.rk_valid && !bus.rk_ready;
                prev_key = bus.rk_out;
                prev_round = bus.rk_round;
            end
        end
    end

    task automatic go(aes_128 key);
        push_expected(key);
        s3 = 1'b0;
        s10 = 1'b0;
        start = 1'b1;
        key_in = key;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (done) return;
        end
        chk("done_timeout", 0, 1);
    endtask

    task automatic wait_round(int r);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (bus.rk_valid && bus.rk_round == 4'(r)) return;
        end
        chk("round_timeout", r, 99);
    endtask

    task automatic check_zero(string nm);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_valid"}, bus.rk_valid, 0);
        chk({nm, "_round"}, bus.rk_round, 0);
        chk({nm, "_key"}, bus.rk_out, 0);
        chk({nm, "_done"}, done, 0);
        chk({nm, "_sword"}, sbox_key_word, 0);
        chk({nm, "_sgen"}, sbox_key_gen, 0);
    endtask

    aes_128 fips, zero, other, rk_a;
    int     x0;

    initial begin
        fips  = from_hex(128'h2b7e151628aed2a6abf7158809cf4f3c);
        zero  = '0;
        other = from_hex(128'h000102030405060708090a0b0c0d0e0f);
        rst_n = 1'b0;
        start = 1'b0;
        key_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // FIPS-197 vector, no backpressure
        x0 = xfers;
        go(fips);
        wait_done();
        @(posedge clk);
        #1;
        chk("fips_xfers", xfers - x0, 11);
        chk("fips_r0", seen[0], fips);
        chk("fips_r1", seen[1],
            from_hex(128'ha0fafe1788542cb123a339392a6c7605));
        chk("fips_r10", seen[10],
            from_hex(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));

        // All-zero key exercises rcon 1b/36
        go(zero);
        wait_done();
        @(posedge clk);
        #1;
        chk("zero_r1", seen[1],
            from_hex(128'h62636363626363636263636362636363));
        chk("zero_r10", seen[10],
            from_hex(128'hb4ef5bcb3e92e21123e951cf6f8f188e));

        // Random backpressure with forced stalls at rounds 3 and 10
        bp_on = 1'b1;
        rnd_rdy = 1'b1;
        x0 = xfers;
        go(fips);
        wait_done();
        bp_on = 1'b0;
        rnd_rdy = 1'b0;
        @(posedge clk);
        #1;
        chk("bp_xfers", xfers - x0, 11);
        chk("bp_r10", seen[10],
            from_hex(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));

        // start while busy must be ignored
        go(fips);
        wait_round(4);
        start = 1'b1;
        key_in = other;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done();
        @(posedge clk);
        #1;
        chk("ign_r10", seen[10],
            from_hex(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));

        // Asynchronous reset mid-cycle at round 6
        go(fips);
        wait_round(6);
        #3;
        mon_off = 1'b1;
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mon_off = 1'b0;
        @(posedge clk);
        #1;
        x0 = xfers;
        go(zero);
        wait_done();
        @(posedge clk);
        #1;
        chk("rst_xfers", xfers - x0, 11);
        chk("rst_r10", seen[10],
            from_hex(128'hb4ef5bcb3e92e21123e951cf6f8f188e));

        // start in the done cycle: back-to-back expansion
        go(zero);
        wait_done();
        x0 = xfers;
        go(fips);
        chk("b2b_valid", bus.rk_valid, 1);
        chk("b2b_round", bus.rk_round, 0);
        chk("b2b_key", bus.rk_out, fips);
        wait_done();
        @(posedge clk);
        #1;
        chk("b2b_xfers", xfers - x0, 11);

        // Random keys under random backpressure
        rnd_rdy = 1'b1;
        for (int n = 0; n < 4; n++) begin
            rk_a = {$urandom, $urandom, $urandom, $urandom};
            go(rk_a);
            wait_done();
        end
        rnd_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", sb.size(), 0);
        chk("idle_valid", bus.rk_valid, 0);
        chk("idle_sword", sbox_key_word, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
